regfile_snapshot_ctrl: RTL
==========================

// Module: regfile_snapshot_ctrl
// PURPOSE
//  Checkpoint/restore sequencer for a RegisterFile that has a dump port.
//  Keeps NSNAPS snapshot slots of the full register-file contents and allocates them on request.
//  On restore, it drives the register file's dump_in / dump_wr_en for exactly one cycle.
//  Sits beside the rename/architectural register file and serves branch checkpointing and flush recovery.
// PARAMETERS
//  DTYPE   8  bit width of one register
//  NREGS   2  number of registers in the controlled register file
//  NSNAPS  4  number of snapshot slots (power of 2, >=2); SW = clog2(NSNAPS)
// PORTS
//  clk            in   1            clock
//  reset          in   1            synchronous, active-high reset
//  rf_dump_out    in   NREGS*DTYPE  current RF contents; reg i at bits [i*DTYPE +: DTYPE]
//  rf_dump_in     out  NREGS*DTYPE  restore data to the RF dump_in, same packing
//  rf_dump_wr_en  out  1            RF dump write enable
//  alloc_call     in   1            take a snapshot; legal only while alloc_rdy=1
//  alloc_rdy      out  1            a free slot exists and the FSM is in IDLE
//  alloc_id       out  SW           slot to be used by this alloc (lowest-index free slot)
//  free_call      in   1            release a slot
//  free_id        in   SW           slot to release
//  restore_call   in   1            restore the RF from a slot; legal only while restore_rdy=1
//  restore_id     in   SW           slot to restore from
//  restore_rdy    out  1            FSM is in IDLE
//  restore_done   out  1            1-cycle pulse; the RF takes the snapshot at the end of this cycle
//  restore_err    out  1            1-cycle pulse; restore requested from an invalid slot
//  num_free       out  SW+1         count of invalid (free) slots
// BEHAVIOUR
//  State: snap[NSNAPS] data, valid[NSNAPS], rst_buf (NREGS*DTYPE), FSM {IDLE, RESTORE}.
//  Reset (synchronous):
//   - all valid = 0; FSM = IDLE
//   - rf_dump_wr_en = 0, restore_done = 0, restore_err = 0, num_free = NSNAPS
//   - snap data and rst_buf are don't-care
//  Alloc: alloc_call & alloc_rdy in cycle T
//   - snap[alloc_id] <= rf_dump_out sampled in T (the pre-edge RF value; RF writes in T are not captured)
//   - valid[alloc_id] = 1 from T+1
//  Free: free_call in cycle T
//   - valid[free_id] = 0 from T+1
//   - freeing an invalid slot is a no-op
//   - a slot freed in T is not offered by alloc until T+1
//  Restore: restore_call & restore_rdy in cycle T
//   - valid[restore_id] = 1: rst_buf <= snap[restore_id]; FSM -> RESTORE at T+1
//   - In RESTORE (cycle T+1): rf_dump_wr_en = 1, rf_dump_in = rst_buf, restore_done = 1, alloc_rdy = restore_rdy = 0
//   - Then unconditionally back to IDLE at T+2
//   - Restore latency: the RF holds the snapshot from T+2
//   - valid[restore_id] = 0: restore_err = 1 in T+1; FSM stays IDLE; no dump write
//   - The restored slot stays valid; the client frees it explicitly.
//  In every other cycle rf_dump_wr_en = 0 and rf_dump_in = 0.
//  Simultaneous events in one IDLE cycle:
//   - alloc + restore: both accepted; the snapshot captures the pre-restore RF
//   - free(x) + restore(x): the restore reads the old data, then x is freed
//   - restore(id) where id is the slot allocated in the same cycle: treated as invalid, err
//   - alloc + free: served by independent slot logic
//   - restore_call while restore_rdy = 0: ignored
//  Full: num_free = 0 -> alloc_rdy = 0; free and restore still work.
//  Reset during RESTORE: the reset has priority; rf_dump_wr_en = 0 in the following cycle.
// TESTING
//  1. Reset, then idle 3 cycles -> num_free=4, alloc_rdy=1, alloc_id=0, rf_dump_wr_en=0.
//  2. RF = {0x11,0x22}; alloc -> id 0. RF then changes to {0x33,0x44}; restore(0)
//     -> rf_dump_wr_en=1 with rf_dump_in={0x11,0x22} exactly 1 cycle later; restore_done pulses.
//  3. Alloc 4 times -> ids 0,1,2,3, num_free=0, alloc_rdy=0. Free(2) -> next cycle alloc_id=2, num_free=1.
//  4. restore(3) when slot 3 is invalid -> restore_err pulse at T+1, rf_dump_wr_en stays 0, FSM stays IDLE.
//  5. alloc + restore(0) in the same cycle -> new slot holds the pre-restore RF; RESTORE cycle blocks alloc_rdy.
//  6. Reset asserted in the RESTORE cycle -> next cycle num_free=4, rf_dump_wr_en=0, restore_rdy=1.

Source files
------------

// File: rtl/regfile_snapshot_ctrl.sv
// Checkpoint/restore sequencer: keeps NSNAPS copies of a register file's contents
// and writes one back through the RF dump port for a single cycle on request.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | accepting alloc / free / restore requests
//  RESTORE | driving rst_buf onto rf_dump_in with rf_dump_wr_en for one cycle
module regfile_snapshot_ctrl #(
    parameter int DTYPE  = 8,
    parameter int NREGS  = 2,
    parameter int NSNAPS = 4,
    localparam int SW    = $clog2(NSNAPS),
    localparam int W     = NREGS * DTYPE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  rf_dump_out,
    output logic [W-1:0]  rf_dump_in,
    output logic          rf_dump_wr_en,
    input  logic          alloc_call,
    output logic          alloc_rdy,
    output logic [SW-1:0] alloc_id,
    input  logic          free_call,
    input  logic [SW-1:0] free_id,
    input  logic          restore_call,
    input  logic [SW-1:0] restore_id,
    output logic          restore_rdy,
    output logic          restore_done,
    output logic          restore_err,
    output logic [SW:0]   num_free
);

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t              state;
    logic [NSNAPS-1:0]   valid;
    logic [W-1:0]        snap [NSNAPS];
    logic [W-1:0]        rst_buf;
    logic                any_free;
    logic                alloc_fire;
    logic                restore_fire;
    logic                restore_hit;

    // Lowest-index free slot and free-slot count, both from the registered valid bits
    // so a slot freed this cycle is only offered from the next one.
    always_comb begin
        alloc_id = '0;
        any_free = 1'b0;
        for (int i = NSNAPS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_id = SW'(i);
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        num_free = '0;
        for (int i = 0; i < NSNAPS; i++) begin
            if (!valid[i]) begin
                num_free = num_free + (SW+1)'(1);
            end
        end
    end

    assign restore_rdy  = (state == IDLE);
    assign alloc_rdy    = restore_rdy && any_free;
    assign alloc_fire   = alloc_call && alloc_rdy;
    assign restore_fire = restore_call && restore_rdy;
    // A slot allocated in this same cycle is not yet valid, so restoring it is an error.
    assign restore_hit  = valid[restore_id];

    assign rf_dump_in   = rf_dump_wr_en ? rst_buf : '0;

    // Slot occupancy; an alloc always targets an invalid slot, so a simultaneous
    // free of that slot is a no-op and the set may safely win.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (free_call) begin
                valid[free_id] <= 1'b0;
            end
            if (alloc_fire) begin
                valid[alloc_id] <= 1'b1;
            end
        end
    end

    // Snapshot storage and restore buffer carry no reset; their contents are
    // meaningless until qualified by valid / rf_dump_wr_en.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            snap[alloc_id] <= rf_dump_out;
        end
        if (restore_fire && restore_hit) begin
            rst_buf <= snap[restore_id];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rf_dump_wr_en <= 1'b0;
            restore_done  <= 1'b0;
            restore_err   <= 1'b0;
        end else begin
            restore_err <= 1'b0;
            case (state)
                IDLE: begin
                    rf_dump_wr_en <= 1'b0;
                    restore_done  <= 1'b0;
                    if (restore_fire) begin
                        if (restore_hit) begin
                            state         <= RESTORE;
                            rf_dump_wr_en <= 1'b1;
                            restore_done  <= 1'b1;
                        end else begin
                            restore_err <= 1'b1;
                        end
                    end
                end
                RESTORE: begin
                    state         <= IDLE;
                    rf_dump_wr_en <= 1'b0;
                    restore_done  <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    rf_dump_wr_en <= 1'b0;
                    restore_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
